// File: rtl/uart_stream_bridge_if.sv
// Byte handshake between the bridge and the UART core.
// The master side is the bridge and the slave side is the UART.
interface uart_stream_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_sent;

  modport master (input rx_data, rx_valid, tx_sent, output tx_data, tx_send);
  modport slave  (output rx_data, rx_valid, tx_sent, input tx_data, tx_send);
endinterface

// File: rtl/uart_stream_bridge.sv
// UART byte-stream bridge: shift-register display window plus an echo FIFO.
// A two-state TX machine drains the FIFO with send/sent handshaking and a timeout.
module uart_stream_bridge #(
  parameter int DISP_BYTES = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 8,
  parameter int TX_TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [1:0]                mode,
  input  logic                      clear,
  uart_stream_bridge_if.master      uart,
  output logic [8*DISP_BYTES-1:0]   disp_value,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          overflow_cnt,
  output logic [CNT_W-1:0]          timeout_cnt,
  output logic                      busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam int WAIT_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (TX_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);
  localparam logic [CNT_FW-1:0] FULL = CNT_FW'(DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_FW-1:0]  count_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [7:0]         tx_data_reg;
  logic               tx_send_reg;
  logic [CNT_W-1:0]   ovf_reg, tmo_reg;

  logic pop, push_req, push, drop, timeout_hit, capture;

  assign capture  = uart.rx_valid && mode[0] && !clear;
  assign push_req = uart.rx_valid && mode[1] && !clear;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push     = push_req && ((count_reg != FULL) || pop);
  assign drop     = push_req && !push;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (pop) state_next = ST_WAIT;
        ST_WAIT: if (uart.tx_sent || timeout_hit) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop         = 1'b0;
    timeout_hit = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      ST_IDLE: pop = (count_reg != '0) && !clear;
      ST_WAIT: begin
        busy        = 1'b1;
        timeout_hit = TIMEOUT_EN && !uart.tx_sent && (wait_cnt_reg == WAIT_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= uart.rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wait_cnt_reg <= '0;
      tx_data_reg  <= '0;
      tx_send_reg  <= 1'b0;
      ovf_reg      <= '0;
      tmo_reg      <= '0;
    end else if (clear) begin
      // tx_data is deliberately left alone so the UART never sees it glitch.
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wait_cnt_reg <= '0;
      tx_send_reg  <= 1'b0;
      ovf_reg      <= '0;
      tmo_reg      <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
        tx_data_reg <= mem[rd_ptr_reg];
      end
      count_reg   <= count_reg + CNT_FW'(push) - CNT_FW'(pop);
      tx_send_reg <= pop;
      if (drop && (ovf_reg != '1))        ovf_reg <= ovf_reg + CNT_W'(1);
      if (timeout_hit && (tmo_reg != '1)) tmo_reg <= tmo_reg + CNT_W'(1);
      if (pop)                       wait_cnt_reg <= '0;
      else if (state_reg == ST_WAIT) wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
    end
  end

  // Display window: byte 0 takes the new byte, every other byte takes its lower neighbour.
  for (genvar gi = 0; gi < DISP_BYTES; gi++) begin : g_win
    logic [7:0] byte_reg;
    logic [7:0] byte_in;
    if (gi == 0) begin : g_head
      assign byte_in = uart.rx_data;
    end else begin : g_tail
      assign byte_in = g_win[gi-1].byte_reg;
    end
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        byte_reg <= '0;
      else if (clear)   byte_reg <= '0;
      else if (capture) byte_reg <= byte_in;
    end
    assign disp_value[8*gi +: 8] = byte_reg;
  end

  assign fifo_count   = count_reg;
  assign overflow_cnt = ovf_reg;
  assign timeout_cnt  = tmo_reg;
  assign uart.tx_data = tx_data_reg;
  assign uart.tx_send = tx_send_reg;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Bench for uart_stream_bridge: directed vectors and sequences on a default instance,
// and a randomized run on a short-timeout instance checked against a queue-based model.
module tb_uart_stream_bridge;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       clear = 1'b0;
  logic       rx_valid = 1'b0;
  logic       tx_sent = 1'b0;
  logic [7:0] rx_data = 8'd0;

  always #5 clk = ~clk;

  uart_stream_bridge_if bus0();
  uart_stream_bridge_if bus1();
  assign bus0.rx_data = rx_data;
  assign bus0.rx_valid = rx_valid;
  assign bus0.tx_sent = tx_sent;
  assign bus1.rx_data = rx_data;
  assign bus1.rx_valid = rx_valid;
  assign bus1.tx_sent = tx_sent;

  logic [31:0] disp0, disp1;
  logic [4:0]  cnt0, cnt1;
  logic [7:0]  ovf0, ovf1, tmo0, tmo1;
  logic        busy0, busy1;

  uart_stream_bridge u0 (
    .clk(clk), .rstn(rstn), .mode(mode), .clear(clear), .uart(bus0),
    .disp_value(disp0), .fifo_count(cnt0), .overflow_cnt(ovf0),
    .timeout_cnt(tmo0), .busy(busy0)
  );

  uart_stream_bridge #(.TX_TIMEOUT(10)) u1 (
    .clk(clk), .rstn(rstn), .mode(mode), .clear(clear), .uart(bus1),
    .disp_value(disp1), .fifo_count(cnt1), .overflow_cnt(ovf1),
    .timeout_cnt(tmo1), .busy(busy1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        clear;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] exp_disp;
    logic [4:0]  exp_count;
  } vec_t;

  vec_t vt[9];

  // Reference model state
  logic [7:0]  m_q[$];
  logic [31:0] m_disp;
  logic [7:0]  m_ovf, m_tmo, m_txd;
  logic        m_busy, m_txs;
  int          m_wait;
  localparam int M_TIMEOUT = 10;

  task automatic model_cycle();
    logic push_req;
    push_req = rx_valid && mode[1] && !clear;
    if (clear) begin
      m_q.delete();
      m_disp = 0; m_ovf = 0; m_tmo = 0; m_busy = 0; m_txs = 0; m_wait = 0;
    end else begin
      if (mode[0] && rx_valid) m_disp = {m_disp[23:0], rx_data};
      m_txs = 1'b0;
      if (m_busy) begin
        if (tx_sent) m_busy = 1'b0;
        else if (m_wait + 1 == M_TIMEOUT) begin
          m_busy = 1'b0;
          if (m_tmo != 8'hFF) m_tmo = m_tmo + 8'd1;
        end else m_wait++;
      end else if (m_q.size() != 0) begin
        m_txd = m_q.pop_front();
        m_txs = 1'b1;
        m_busy = 1'b1;
        m_wait = 0;
      end
      if (push_req) begin
        if (m_q.size() < 16) m_q.push_back(rx_data);
        else if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
      end
    end
  endtask

  initial begin
    int sends, got, cyc, hi;
    logic [62:0] act_v, exp_v;

    vt[0] = '{2'd1, 1'b0, 1'b1, 8'h12, 32'h00000012, 5'd0};
    vt[1] = '{2'd1, 1'b0, 1'b1, 8'h34, 32'h00001234, 5'd0};
    vt[2] = '{2'd1, 1'b0, 1'b1, 8'h56, 32'h00123456, 5'd0};
    vt[3] = '{2'd1, 1'b0, 1'b1, 8'h78, 32'h12345678, 5'd0};
    vt[4] = '{2'd1, 1'b0, 1'b1, 8'h9A, 32'h3456789A, 5'd0};
    vt[5] = '{2'd0, 1'b0, 1'b1, 8'hFF, 32'h3456789A, 5'd0};
    vt[6] = '{2'd1, 1'b0, 1'b0, 8'h55, 32'h3456789A, 5'd0};
    vt[7] = '{2'd1, 1'b1, 1'b1, 8'hEE, 32'h00000000, 5'd0};
    vt[8] = '{2'd1, 1'b0, 1'b1, 8'h11, 32'h00000011, 5'd0};

    // Reset state
    #1 rstn = 1'b0;
    #2;
    chk("rst_disp", disp0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_tmo", tmo0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_tx_send", bus0.tx_send, 0);
    chk("rst_tx_data", bus0.tx_data, 0);
    step();
    rstn = 1'b1;

    // Capture window vectors
    sends = 0;
    for (int i = 0; i < 9; i++) begin
      mode = vt[i].mode; clear = vt[i].clear;
      rx_valid = vt[i].rx_valid; rx_data = vt[i].rx_data;
      step();
      if (bus0.tx_send) sends++;
      chk($sformatf("vec%0d_disp", i), disp0, vt[i].exp_disp);
      chk($sformatf("vec%0d_count", i), cnt0, vt[i].exp_count);
      $display("vec %0d mode=%0d rx=%h disp=%h", i, vt[i].mode, vt[i].rx_data, disp0);
    end
    rx_valid = 1'b0; clear = 1'b0;
    step();
    if (bus0.tx_send) sends++;
    chk("capture_no_tx_send", sends, 0);

    // Single echo latency and completion
    do_clear();
    mode = 2'd2; rx_valid = 1'b1; rx_data = 8'hA5;
    step();
    rx_valid = 1'b0;
    chk("echo_count_t1", cnt0, 1);
    chk("echo_no_send_t1", bus0.tx_send, 0);
    step();
    chk("echo_send_t2", bus0.tx_send, 1);
    chk("echo_data_t2", bus0.tx_data, 8'hA5);
    chk("echo_busy_t2", busy0, 1);
    repeat (4) step();
    tx_sent = 1'b1;
    step();
    tx_sent = 1'b0;
    chk("echo_done_busy", busy0, 0);
    chk("echo_done_count", cnt0, 0);
    $display("echo byte=a5 completed");

    // Fill, overflow, then in-order drain
    do_clear();
    mode = 2'd2;
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1'b1; rx_data = 8'h40 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    chk("fill_count", cnt0, 16);
    chk("fill_ovf", ovf0, 0);
    chk("fill_first_pop", bus0.tx_data, 8'h40);
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1; rx_data = 8'h60 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    chk("overflow_cnt", ovf0, 2);
    chk("overflow_count", cnt0, 16);
    got = 0; cyc = 0;
    tx_sent = 1'b1; step(); tx_sent = 1'b0;
    while (got < 16 && cyc < 400) begin
      step(); cyc++;
      if (bus0.tx_send) begin
        chk($sformatf("drain_order%0d", got), bus0.tx_data, 8'h41 + 8'(got));
        $display("drain byte=%h", bus0.tx_data);
        got++;
        step(); tx_sent = 1'b1; step(); tx_sent = 1'b0;
      end
    end
    chk("drain_total", got, 16);
    chk("drain_empty", cnt0, 0);

    // Push into a full FIFO on the pop edge
    do_clear();
    mode = 2'd2;
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1'b1; rx_data = 8'h80 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    tx_sent = 1'b1; step(); tx_sent = 1'b0;
    chk("full_idle_busy", busy0, 0);
    chk("full_idle_count", cnt0, 16);
    rx_valid = 1'b1; rx_data = 8'hC0;
    step();
    rx_valid = 1'b0;
    chk("full_pop_send", bus0.tx_send, 1);
    chk("full_pop_data", bus0.tx_data, 8'h81);
    chk("full_push_count", cnt0, 16);
    chk("full_push_ovf", ovf0, 0);

    // Timeout on the TX_TIMEOUT=10 instance
    do_clear();
    mode = 2'd2; rx_valid = 1'b1; rx_data = 8'h5A;
    step();
    rx_data = 8'h6B;
    step();
    rx_valid = 1'b0;
    chk("to_send", bus1.tx_send, 1);
    chk("to_data", bus1.tx_data, 8'h5A);
    hi = 0;
    for (int i = 1; i < 10; i++) begin
      step();
      if (busy1) hi++;
    end
    chk("to_busy_cycles", hi, 9);
    step();
    chk("to_idle", busy1, 0);
    chk("to_tmo_cnt", tmo1, 1);
    step();
    chk("to_next_send", bus1.tx_send, 1);
    chk("to_next_data", bus1.tx_data, 8'h6B);

    // Clear during WAIT with bytes queued, then reset mid-WAIT
    do_clear();
    mode = 2'd3;
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = 8'hD0 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    chk("pre_clear_count", cnt0, 5);
    chk("pre_clear_busy", busy0, 1);
    clear = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    step();
    clear = 1'b0; rx_valid = 1'b0;
    chk("clear_count", cnt0, 0);
    chk("clear_disp", disp0, 0);
    chk("clear_busy", busy0, 0);
    chk("clear_tx_send", bus0.tx_send, 0);
    chk("clear_keeps_tx_data", bus0.tx_data, 8'hD0);
    step();
    chk("clear_rx_discarded", cnt0, 0);
    mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'h77 + 8'(i);
      step();
    end
    rx_valid = 1'b0;
    chk("mid_wait_busy", busy0, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_outputs", {disp0, cnt0, ovf0, tmo0, busy0, bus0.tx_send, bus0.tx_data}, 0);
    sends = 0;
    repeat (3) begin step(); if (bus0.tx_send) sends++; end
    rstn = 1'b1;
    repeat (3) begin step(); if (bus0.tx_send) sends++; end
    chk("rst_no_send", sends, 0);
    chk("rst_release_busy", busy0, 0);

    // Randomized run against the model on the short-timeout instance
    rstn = 1'b0; step(); rstn = 1'b1;
    m_q.delete();
    m_disp = 0; m_ovf = 0; m_tmo = 0; m_txd = 0; m_busy = 0; m_txs = 0; m_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      mode     = 2'($urandom_range(0, 3));
      rx_valid = ($urandom_range(0, 99) < 40);
      rx_data  = 8'($urandom_range(0, 255));
      clear    = ($urandom_range(0, 199) == 0);
      tx_sent  = ($urandom_range(0, 99) < 15);
      model_cycle();
      step();
      act_v = {disp1, cnt1, ovf1, tmo1, busy1, bus1.tx_send, bus1.tx_data};
      exp_v = {m_disp, 5'(m_q.size()), m_ovf, m_tmo, m_busy, m_txs, m_txd};
      chk($sformatf("rand_cycle%0d", c), act_v, exp_v);
      if (m_txs) $display("rand tx byte=%h cycle=%0d", m_txd, c);
    end
    rx_valid = 1'b0; clear = 1'b0; tx_sent = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
